// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 integer registers with x0 hardwired to
// zero, two combinational decode read ports with same-cycle WB->ID bypass,
// a one-cycle registered commit trace and a retired-instruction counter.
module wb_regfile #(
  parameter int                     INST_LENGTH     = 32,
  parameter int                     DATA_LENGTH     = 32,
  parameter int                     REG_ADDR_LENGTH = 5,
  parameter logic [INST_LENGTH-1:0] NOP_INST        = 32'h00000013,
  parameter int                     CNT_LENGTH      = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INST_LENGTH-1:0]     i_inst,
  input  logic [DATA_LENGTH-1:0]     i_wbout,
  input  logic [REG_ADDR_LENGTH-1:0] i_rd,
  input  logic                       i_regWEn,
  input  logic [REG_ADDR_LENGTH-1:0] i_rs1,
  input  logic [REG_ADDR_LENGTH-1:0] i_rs2,
  output logic [DATA_LENGTH-1:0]     o_rs1_data,
  output logic [DATA_LENGTH-1:0]     o_rs2_data,
  output logic                       o_commit_vld,
  output logic [REG_ADDR_LENGTH-1:0] o_commit_rd,
  output logic [DATA_LENGTH-1:0]     o_commit_data,
  output logic [CNT_LENGTH-1:0]      o_instret
);

  localparam int NREG = 2 ** REG_ADDR_LENGTH;
  localparam logic [CNT_LENGTH-1:0] CNT_ONE = {{(CNT_LENGTH-1){1'b0}}, 1'b1};

  // Entry 0 exists only to keep indexing simple; it is never written and
  // never read (reads of x0 are short-circuited to zero).
  logic [DATA_LENGTH-1:0] rf [NREG];

  logic wr_en;
  logic retire;

  // A write to x0 is a no-op, both for storage and for bypass/commit trace.
  assign wr_en  = i_regWEn && (i_rd != '0);
  // Bubbles and flushed (all-zero) slots do not count as retired.
  assign retire = (i_inst != NOP_INST) && (i_inst != '0);

  // Read-port mux: x0 reads zero, a matching in-flight write is forwarded,
  // otherwise the stored value is returned.
  function automatic logic [DATA_LENGTH-1:0] read_sel(
    input logic [REG_ADDR_LENGTH-1:0] rs,
    input logic [DATA_LENGTH-1:0]     stored,
    input logic                       wen,
    input logic [REG_ADDR_LENGTH-1:0] rd,
    input logic [DATA_LENGTH-1:0]     wdata
  );
    logic [DATA_LENGTH-1:0] res;
    res = stored;
    if (rs == '0) begin
      res = '0;
    end else if (wen && (rd == rs)) begin
      res = wdata;
    end
    return res;
  endfunction

  // Register array update: cleared on reset, otherwise commit the WB write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_en) begin
      rf[i_rd] <= i_wbout;
    end
  end

  // Decode read ports; held at zero while reset is asserted.
  always_comb begin
    o_rs1_data = '0;
    o_rs2_data = '0;
    if (rst_n) begin
      o_rs1_data = read_sel(i_rs1, rf[i_rs1], wr_en, i_rd, i_wbout);
      o_rs2_data = read_sel(i_rs2, rf[i_rs2], wr_en, i_rd, i_wbout);
    end
  end

  // Commit trace: valid pulses for one cycle after a real write; index and
  // data hold their last committed values otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_commit_vld  <= 1'b0;
      o_commit_rd   <= '0;
      o_commit_data <= '0;
    end else begin
      o_commit_vld <= wr_en;
      if (wr_en) begin
        o_commit_rd   <= i_rd;
        o_commit_data <= i_wbout;
      end
    end
  end

  // Retired-instruction counter, wrapping naturally at its width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_instret <= '0;
    end else if (retire) begin
      o_instret <= o_instret + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed, table-driven bench for wb_regfile plus a counter-wrap sequence
// on a narrow-counter instance.
module tb_wb_regfile;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] ADD = 32'h002081b3;
  localparam logic [31:0] SW  = 32'h0020a023;
  localparam logic [31:0] BEQ = 32'h00208463;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic [31:0] wbout;
  logic [4:0]  rd;
  logic        wen;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        commit_vld;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [63:0] instret;

  logic        w_rst_n;
  logic [31:0] w_inst;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic        w_commit_vld;
  logic [4:0]  w_commit_rd;
  logic [31:0] w_commit_data;
  logic [2:0]  w_instret;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk(clk), .rst_n(rst_n), .i_inst(inst), .i_wbout(wbout), .i_rd(rd),
    .i_regWEn(wen), .i_rs1(rs1), .i_rs2(rs2),
    .o_rs1_data(rs1_data), .o_rs2_data(rs2_data),
    .o_commit_vld(commit_vld), .o_commit_rd(commit_rd),
    .o_commit_data(commit_data), .o_instret(instret)
  );

  wb_regfile #(.CNT_LENGTH(3)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .i_inst(w_inst), .i_wbout(32'h0), .i_rd(5'd0),
    .i_regWEn(1'b0), .i_rs1(5'd0), .i_rs2(5'd0),
    .o_rs1_data(w_rs1_data), .o_rs2_data(w_rs2_data),
    .o_commit_vld(w_commit_vld), .o_commit_rd(w_commit_rd),
    .o_commit_data(w_commit_data), .o_instret(w_instret)
  );

  typedef struct {
    logic        rst_n;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wbout;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e_rs1;    // combinational, before the edge
    logic [31:0] e_rs2;
    logic        e_cvld;   // registered, after the edge
    logic [4:0]  e_crd;
    logic [31:0] e_cdata;
    logic [63:0] e_ret;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst_n = v.rst_n; inst = v.inst; wen = v.wen; rd = v.rd;
    wbout = v.wbout; rs1 = v.rs1; rs2 = v.rs2;
    #1;
    check("rs1_data", idx, 64'(rs1_data), 64'(v.e_rs1));
    check("rs2_data", idx, 64'(rs2_data), 64'(v.e_rs2));
    @(posedge clk);
    #1;
    check("commit_vld",  idx, 64'(commit_vld),  64'(v.e_cvld));
    check("commit_rd",   idx, 64'(commit_rd),   64'(v.e_crd));
    check("commit_data", idx, 64'(commit_data), 64'(v.e_cdata));
    check("instret",     idx, instret, v.e_ret);
  endtask

  task automatic wrap_step(input logic r, input logic [31:0] i);
    @(negedge clk);
    w_rst_n = r; w_inst = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           rst   inst  wen   rd     wbout          rs1    rs2    e_rs1          e_rs2          cvld  crd     cdata          ret
    vecs[0]  = '{1'b0, ADD, 1'b1, 5'd3,  32'h00000055, 5'd3,  5'd5,  32'h0,         32'h0,         1'b0, 5'd0,  32'h0,         64'd0};
    vecs[1]  = '{1'b1, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0,  32'hDEADBEEF,  32'h0,         1'b1, 5'd5,  32'hDEADBEEF,  64'd0};
    vecs[2]  = '{1'b1, 32'h0, 1'b0, 5'd5, 32'h00001234, 5'd5, 5'd3,  32'hDEADBEEF,  32'h0,         1'b0, 5'd5,  32'hDEADBEEF,  64'd0};
    vecs[3]  = '{1'b1, 32'h0, 1'b1, 5'd7, 32'h00000001, 5'd7, 5'd7,  32'h1,         32'h1,         1'b1, 5'd7,  32'h1,         64'd0};
    vecs[4]  = '{1'b1, 32'h0, 1'b1, 5'd7, 32'h00000002, 5'd7, 5'd7,  32'h2,         32'h2,         1'b1, 5'd7,  32'h2,         64'd0};
    vecs[5]  = '{1'b1, 32'h0, 1'b0, 5'd7, 32'h00000009, 5'd7, 5'd7,  32'h2,         32'h2,         1'b0, 5'd7,  32'h2,         64'd0};
    vecs[6]  = '{1'b1, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5,  32'h0,         32'hDEADBEEF,  1'b0, 5'd7,  32'h2,         64'd0};
    vecs[7]  = '{1'b1, 32'h0, 1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7,  32'h0,         32'h2,         1'b0, 5'd7,  32'h2,         64'd0};
    vecs[8]  = '{1'b1, ADD,  1'b1, 5'd9, 32'h00000099, 5'd9, 5'd1,  32'h99,        32'h0,         1'b1, 5'd9,  32'h99,        64'd1};
    vecs[9]  = '{1'b1, NOP,  1'b0, 5'd9, 32'h0,        5'd9, 5'd9,  32'h99,        32'h99,        1'b0, 5'd9,  32'h99,        64'd1};
    vecs[10] = '{1'b1, 32'h0, 1'b0, 5'd9, 32'h0,       5'd9, 5'd7,  32'h99,        32'h2,         1'b0, 5'd9,  32'h99,        64'd1};
    vecs[11] = '{1'b1, SW,   1'b0, 5'd9, 32'h0,        5'd5, 5'd9,  32'hDEADBEEF,  32'h99,        1'b0, 5'd9,  32'h99,        64'd2};
    vecs[12] = '{1'b1, BEQ,  1'b0, 5'd9, 32'h0,        5'd7, 5'd5,  32'h2,         32'hDEADBEEF,  1'b0, 5'd9,  32'h99,        64'd3};
    vecs[13] = '{1'b0, ADD,  1'b1, 5'd3, 32'h0000ABCD, 5'd3, 5'd9,  32'h0,         32'h0,         1'b0, 5'd0,  32'h0,         64'd0};
    vecs[14] = '{1'b1, 32'h0, 1'b0, 5'd3, 32'h0,       5'd3, 5'd9,  32'h0,         32'h0,         1'b0, 5'd0,  32'h0,         64'd0};
    vecs[15] = '{1'b1, 32'h0, 1'b1, 5'd31, 32'h80000000, 5'd31, 5'd5, 32'h80000000, 32'h0,        1'b1, 5'd31, 32'h80000000,  64'd0};

    rst_n = 1'b0; inst = '0; wen = 1'b0; rd = '0; wbout = '0; rs1 = '0; rs2 = '0;
    w_rst_n = 1'b0; w_inst = '0;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i], i);
    end

    // Narrow counter: 7 retires reach the all-ones value, the 8th wraps to 0.
    wrap_step(1'b0, ADD);
    check("wrap_reset", 0, 64'(w_instret), 64'd0);
    for (int k = 0; k < 7; k++) begin
      wrap_step(1'b1, ADD);
    end
    check("wrap_max", 0, 64'(w_instret), 64'd7);
    wrap_step(1'b1, SW);
    check("wrap_zero", 0, 64'(w_instret), 64'd0);
    wrap_step(1'b1, NOP);
    check("wrap_nop", 0, 64'(w_instret), 64'd0);
    wrap_step(1'b1, BEQ);
    check("wrap_one", 0, 64'(w_instret), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
